alu_console: RTL
================

# alu_console

Parametrised operand-entry, iterative-multiply and display-mux front end for the ALU lab board. It sits between the touchscreen/LCD module and the combinational ALU. It captures control and operand words from the touchscreen, drives them to the ALU, and runs a signed or unsigned shift-add multiplier over DATA_W cycles. It also serves a registered, numbered display-slot readout back to the LCD module.

## Interface
- DATA_W, 32: operand width; legal range 8–32, even.
- CTRL_W, 14: ALU control-word width; legal range 4–32.
- MUL_BIT, 2: index of the control bit that selects multiply.
- SIGN_BIT, 3: index of the control bit that selects a signed multiply (1 = signed).

Ports:
- clk  in  1  system clock (10 MHz).
- reset  in  1  synchronous reset, active-high.
- input_valid  in  1  one-cycle strobe from the touchscreen.
- input_sel  in  2  write target: 01 = ctrl, 10 = src1, 11 = src2, 00 = ignored.
- input_value  in  32  touchscreen value; low bits are used.
- alu_control  out  CTRL_W  registered control word.
- alu_src1, alu_src2  out  DATA_W  registered operands.
- alu_result, alu_aux  in  DATA_W  ALU result and remainder.
- display_number  in  6  slot requested by the LCD.
- display_valid  out  1  slot is populated.
- display_name  out  40  5-char ASCII name, left-justified and space-padded.
- display_value  out  32  slot value, zero-extended from DATA_W.
- mul_busy  out  1  multiplier is running.
- mul_done  out  1  one-cycle pulse when a product lands.

## Operation
- Write path:
  - An input_valid edge writes the register selected by input_sel: ctrl gets input_value[CTRL_W-1:0]; src1 and src2 get input_value[DATA_W-1:0].
  - Any such write, when the post-write ctrl has MUL_BIT = 1, sets start_pending.
- FSM states IDLE, BUSY, DONE:
  - IDLE→BUSY when start_pending is set. On entry: load |src1| and |src2| (magnitudes if SIGN_BIT = 1, otherwise raw), record the result sign (src1 MSB xor src2 MSB, signed mode only), clear the accumulator and start_pending, and set the counter to DATA_W.
  - BUSY: one shift-add step per cycle. When the counter reaches 0, go to DONE. In signed mode the product is negated if the recorded sign is 1. The 2·DATA_W product is written to hi/lo on the DONE-entry edge.
  - DONE→IDLE next cycle, or →BUSY if start_pending was set meanwhile.
- Restart: a triggering write during BUSY sets start_pending. The FSM aborts, returns to IDLE the next cycle (hi/lo unchanged, no mul_done), then restarts with the new operands.
- Clearing MUL_BIT during BUSY aborts the run the same way, with no restart.
- Display slots (others → valid 0, name 0, value 0):
  - 1 SRC_1 = src1
  - 2 SRC_2 = src2
  - 3 CONTR = ctrl
  - 4 RESUL = alu_result
  - 5 ODD = alu_aux
  - 6 HIGH = hi
  - 7 LOW = lo
  - 8 STAT = {busy, done_sticky, 0…, cycle_count[7:0]}
- HIGH and LOW read 0 whenever MUL_BIT = 0.
- done_sticky: set on mul_done; cleared on any write and on reset.

## Timing
- Write accepted at edge E: the register is visible after E.
- A triggering write at E gives BUSY from E+1, DONE entry at E+1+DATA_W, and hi/lo valid with mul_done high in the cycle after that edge. Total: DATA_W+2 edges from the write to a readable product.
- Display outputs are registered, with one cycle of latency from display_number.
- Reset:
  - All outputs and registers go to 0; state goes to IDLE.
  - Reset mid-BUSY discards the run; mul_done is not pulsed.
  - Reset has priority over input_valid in the same cycle.

## Configuration
- ALU_CONSOLE_MUL_EN defined: multiplier FSM and hi/lo registers are present.
- ALU_CONSOLE_MUL_EN undefined:
  - The FSM is not built.
  - mul_busy and mul_done are tied to 0.
  - Slots 6 and 7 report valid 1 with value 0.
  - STAT busy, done and count bits read 0.
  - Write capture and the display path are unchanged.

## Structure
- Package alu_console_pkg holds:
  - the state enum (IDLE/BUSY/DONE);
  - slot-number constants (SLOT_SRC1…SLOT_STAT);
  - the 40-bit name constants;
  - the input_sel encodings.
- Sub-module iter_mult holds the shift-add datapath, counter and sign handling, with a start/busy/done handshake. The top level keeps write capture, the restart/abort logic and the display mux.

## Test plan
- Unsigned, DATA_W=32: ctrl=0x0004, src1=3, src2=5 → mul_done 34 cycles after the last write; HIGH=0, LOW=0xF.
- Signed, ctrl=0x000C: src1=0xFFFFFFFE, src2=3 → HIGH=0xFFFFFFFF, LOW=0xFFFFFFFA.
- Unsigned 0xFFFFFFFF × 0xFFFFFFFF → HIGH=0xFFFFFFFE, LOW=0x00000001.
- Write src2=7 at cycle 10 of a 3×5 run → no mul_done for the first run; the restarted run ends with LOW=0x15.
- Assert reset at cycle 20 of BUSY → mul_busy=0 next cycle; all slots read 0 and no mul_done pulse occurs.
- Display sweep of display_number 0–9 → valid 0 for slots 0 and 9; slot 3 name "CONTR"; each value appears one cycle after the request.

Source files
------------

// File: rtl/alu_console_pkg.sv
// Shared types and constants for the ALU lab-board console: multiplier states,
// display slot numbers, slot names and touchscreen write-target encodings.
package alu_console_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_CTRL = 2'b01;
    localparam logic [1:0] SEL_SRC1 = 2'b10;
    localparam logic [1:0] SEL_SRC2 = 2'b11;

    localparam logic [5:0] SLOT_SRC1  = 6'd1;
    localparam logic [5:0] SLOT_SRC2  = 6'd2;
    localparam logic [5:0] SLOT_CONTR = 6'd3;
    localparam logic [5:0] SLOT_RESUL = 6'd4;
    localparam logic [5:0] SLOT_ODD   = 6'd5;
    localparam logic [5:0] SLOT_HIGH  = 6'd6;
    localparam logic [5:0] SLOT_LOW   = 6'd7;
    localparam logic [5:0] SLOT_STAT  = 6'd8;

    // Five ASCII characters, left-justified and space-padded.
    localparam logic [39:0] NAME_SRC1  = "SRC_1";
    localparam logic [39:0] NAME_SRC2  = "SRC_2";
    localparam logic [39:0] NAME_CONTR = "CONTR";
    localparam logic [39:0] NAME_RESUL = "RESUL";
    localparam logic [39:0] NAME_ODD   = "ODD  ";
    localparam logic [39:0] NAME_HIGH  = "HIGH ";
    localparam logic [39:0] NAME_LOW   = "LOW  ";
    localparam logic [39:0] NAME_STAT  = "STAT ";

endpackage

// File: rtl/iter_mult.sv
// Iterative shift-add multiplier: one partial product per cycle over DATA_W
// cycles, magnitude/sign handling for signed operands, start/busy/done handshake.
module iter_mult
    import alu_console_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic              signed_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              start_ack_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic [7:0]        steps_o
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    mul_state_e          state_q, state_d;
    logic [DATA_W-1:0]   mcand_q;
    logic [2*DATA_W-1:0] prod_q;
    logic                neg_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   hi_q, lo_q;
    logic [7:0]          steps_q;

    logic                step_en, finish;
    logic [DATA_W:0]     partial;
    logic [2*DATA_W-1:0] prod_step, prod_final;
    logic [DATA_W-1:0]   a_mag, b_mag;

    assign a_mag = (signed_i && a_i[DATA_W-1]) ? -a_i : a_i;
    assign b_mag = (signed_i && b_i[DATA_W-1]) ? -b_i : b_i;

    // Upper half accumulates the multiplicand; the multiplier shifts out of the lower half.
    assign partial    = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    assign prod_step  = {partial, prod_q[DATA_W-1:1]};
    assign prod_final = neg_q ? -prod_step : prod_step;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        start_ack_o = 1'b0;
        step_en     = 1'b0;
        finish      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = BUSY;
                    start_ack_o = 1'b1;
                end
            end
            BUSY: begin
                if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    step_en = 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = DONE;
                        finish  = 1'b1;
                    end
                end
            end
            DONE: begin
                if (start_i) begin
                    state_d     = BUSY;
                    start_ack_o = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it is tested inside the clocked block, and state uses <= only.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mcand_q <= '0;
            prod_q  <= '0;
            neg_q   <= 1'b0;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            steps_q <= '0;
        end else begin
            state_q <= state_d;
            if (start_ack_o) begin
                mcand_q <= a_mag;
                prod_q  <= {{DATA_W{1'b0}}, b_mag};
                neg_q   <= signed_i && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                cnt_q   <= CNT_W'(DATA_W);
                steps_q <= '0;
            end else if (step_en) begin
                prod_q  <= prod_step;
                cnt_q   <= cnt_q - CNT_W'(1);
                steps_q <= steps_q + 8'd1;
                if (finish) begin
                    {hi_q, lo_q} <= prod_final;
                end
            end
        end
    end

    assign busy_o  = (state_q == BUSY);
    assign done_o  = (state_q == DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;
    assign steps_o = steps_q;

endmodule

// File: rtl/alu_console.sv
// ALU lab-board console: touchscreen write capture, optional iterative multiplier
// (built when ALU_CONSOLE_MUL_EN is defined) and a registered numbered display mux.
module alu_console
    import alu_console_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 14,
    parameter int MUL_BIT  = 2,
    parameter int SIGN_BIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              input_valid,
    input  logic [1:0]        input_sel,
    input  logic [31:0]       input_value,
    output logic [CTRL_W-1:0] alu_control,
    output logic [DATA_W-1:0] alu_src1,
    output logic [DATA_W-1:0] alu_src2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] alu_aux,
    input  logic [5:0]        display_number,
    output logic              display_valid,
    output logic [39:0]       display_name,
    output logic [31:0]       display_value,
    output logic              mul_busy,
    output logic              mul_done
);
    if (DATA_W < 8 || DATA_W > 32 || (DATA_W % 2) != 0 || CTRL_W < 4 || CTRL_W > 32 ||
        MUL_BIT >= CTRL_W || SIGN_BIT >= CTRL_W) begin : g_bad_params
        $error("alu_console: illegal parameter set");
    end

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d;
    logic              disp_valid_q, disp_valid_d;
    logic [39:0]       disp_name_q, disp_name_d;
    logic [31:0]       disp_value_q, disp_value_d;
    logic [DATA_W-1:0] hi_view, lo_view;
    logic [31:0]       stat_word;

    always_comb begin
        ctrl_d = ctrl_q;
        src1_d = src1_q;
        src2_d = src2_q;
        if (input_valid) begin
            case (input_sel)
                SEL_CTRL: ctrl_d = input_value[CTRL_W-1:0];
                SEL_SRC1: src1_d = input_value[DATA_W-1:0];
                SEL_SRC2: src2_d = input_value[DATA_W-1:0];
                default:  ;
            endcase
        end
    end

`ifdef ALU_CONSOLE_MUL_EN
    logic              wr_en, start_pending_q, start_pending_d;
    logic              done_sticky_q, done_sticky_d;
    logic              start_ack, mult_busy, mult_done;
    logic [DATA_W-1:0] mult_hi, mult_lo;
    logic [7:0]        mult_steps;

    assign wr_en = input_valid && (input_sel != SEL_NONE);

    // A new trigger outranks the acknowledge so a write landing on BUSY entry still restarts.
    always_comb begin
        start_pending_d = start_pending_q;
        done_sticky_d   = done_sticky_q;
        if (start_ack)                start_pending_d = 1'b0;
        if (wr_en && ctrl_d[MUL_BIT]) start_pending_d = 1'b1;
        if (mult_done)                done_sticky_d   = 1'b1;
        if (wr_en)                    done_sticky_d   = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            start_pending_q <= 1'b0;
            done_sticky_q   <= 1'b0;
        end else begin
            start_pending_q <= start_pending_d;
            done_sticky_q   <= done_sticky_d;
        end
    end

    iter_mult #(
        .DATA_W(DATA_W)
    ) u_iter_mult (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start_pending_q),
        .abort_i    (start_pending_q || !ctrl_q[MUL_BIT]),
        .signed_i   (ctrl_q[SIGN_BIT]),
        .a_i        (src1_q),
        .b_i        (src2_q),
        .start_ack_o(start_ack),
        .busy_o     (mult_busy),
        .done_o     (mult_done),
        .hi_o       (mult_hi),
        .lo_o       (mult_lo),
        .steps_o    (mult_steps)
    );

    assign mul_busy  = mult_busy;
    assign mul_done  = mult_done;
    assign hi_view   = ctrl_q[MUL_BIT] ? mult_hi : '0;
    assign lo_view   = ctrl_q[MUL_BIT] ? mult_lo : '0;
    assign stat_word = {mult_busy, done_sticky_q, 22'd0, mult_steps};
`else
    assign mul_busy  = 1'b0;
    assign mul_done  = 1'b0;
    assign hi_view   = '0;
    assign lo_view   = '0;
    assign stat_word = '0;
`endif

    always_comb begin
        disp_valid_d = 1'b1;
        disp_name_d  = '0;
        disp_value_d = '0;
        case (display_number)
            SLOT_SRC1:  begin disp_name_d = NAME_SRC1;  disp_value_d = 32'(src1_q);     end
            SLOT_SRC2:  begin disp_name_d = NAME_SRC2;  disp_value_d = 32'(src2_q);     end
            SLOT_CONTR: begin disp_name_d = NAME_CONTR; disp_value_d = 32'(ctrl_q);     end
            SLOT_RESUL: begin disp_name_d = NAME_RESUL; disp_value_d = 32'(alu_result); end
            SLOT_ODD:   begin disp_name_d = NAME_ODD;   disp_value_d = 32'(alu_aux);    end
            SLOT_HIGH:  begin disp_name_d = NAME_HIGH;  disp_value_d = 32'(hi_view);    end
            SLOT_LOW:   begin disp_name_d = NAME_LOW;   disp_value_d = 32'(lo_view);    end
            SLOT_STAT:  begin disp_name_d = NAME_STAT;  disp_value_d = stat_word;       end
            default:    disp_valid_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q       <= '0;
            src1_q       <= '0;
            src2_q       <= '0;
            disp_valid_q <= 1'b0;
            disp_name_q  <= '0;
            disp_value_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            src1_q       <= src1_d;
            src2_q       <= src2_d;
            disp_valid_q <= disp_valid_d;
            disp_name_q  <= disp_name_d;
            disp_value_q <= disp_value_d;
        end
    end

    assign alu_control   = ctrl_q;
    assign alu_src1      = src1_q;
    assign alu_src2      = src2_q;
    assign display_valid = disp_valid_q;
    assign display_name  = disp_name_q;
    assign display_value = disp_value_q;

endmodule
